dual_rail_lut_seq: RTL and testbench
====================================

# dual_rail_lut_seq

Sequential, parametrised dual-rail lookup-table engine. Accepts an IN_W-bit operand in complementary rails, checks rail validity, runs a precharge phase, then drives a table lookup result on complementary output rails for one evaluate cycle. The table is run-time writable. It extends the combinational dual-rail sample LUT with:
- operand/result width generics
- a precharge/evaluate sequencer
- a handshake
- sticky rail-error detection

## Interface

Parameters:
- IN_W, default 8: operand width; table depth is 2**IN_W.
- OUT_W, default 8: result width.
- PRE_CYC, default 1: precharge cycles per transaction; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in  input  IN_W  true rail of the operand.
- inbar  input  IN_W  complement rail of the operand.
- cfg_we  input  1  table write enable.
- cfg_addr  input  IN_W  table write address.
- cfg_data  input  OUT_W  table write data.
- out  output  OUT_W  true rail of the result.
- outbar  output  OUT_W  complement rail of the result.
- out_valid  output  1  result present this cycle.
- err  output  1  sticky rail-violation flag.
- err_clr  input  1  clears err.

## Operation

- **Table.** 2**IN_W entries of OUT_W bits. Reset value is identity: entry i = i[OUT_W-1:0], zero-extended when OUT_W > IN_W. A write with cfg_we=1 updates entry cfg_addr at the clock edge; writes are allowed in every state.
- **Handshake.** A transfer occurs at an edge where in_valid && in_ready. in_ready = 1 only in IDLE. There is no output backpressure.
- **Rail check at accept.** The operand is valid iff (in ^ inbar) is all ones.
  - Valid: latch in as the address and go to PRE.
  - Invalid: set err, drop the operand, stay in IDLE. out_valid is never raised for a dropped operand.
- **FSM states:**
  - IDLE: out = outbar = 0 (precharged), out_valid = 0. On a valid transfer go to PRE and load the counter with PRE_CYC-1.
  - PRE: out = outbar = 0, in_ready = 0. The counter decrements each cycle. When the counter is 0, go to EVAL at the next edge.
  - EVAL: out = table[addr], outbar = ~table[addr], out_valid = 1, for exactly one cycle. Next state is always IDLE.
- **Output registers.** out, outbar and out_valid are registered, with no combinational path from any input.
- **Table read timing.** The EVAL data is read at the PRE→EVAL edge. A cfg write to the same address on that same edge is not visible; the old contents are output.
- **Rail invariant.** out and outbar are never both 1 in any bit, in any state.
- **err behaviour.** err is set on an invalid transfer and cleared by err_clr. If set and clear occur on the same edge, set wins. err has no effect on the FSM.
- **Reset.** Asserting rst at any time, including mid-PRE or in EVAL, asynchronously forces:
  - state = IDLE
  - out = outbar = 0, out_valid = 0, err = 0
  - table = identity
  - in_ready = 1 once rst is deasserted

  Any in-flight transaction is lost and produces no out_valid.

## Timing

- For an operand accepted at edge N:
  - PRE occupies the cycles after edges N .. N+PRE_CYC-1.
  - EVAL is the cycle after edge N+PRE_CYC; out_valid is sampled high at edge N+PRE_CYC+1.
  - IDLE is re-entered after edge N+PRE_CYC+1, and in_ready is high again in that cycle.
- Lookup latency is PRE_CYC+1 edges from accept to the out_valid sample.
- Maximum throughput is one operand per PRE_CYC+2 cycles.
- With the defaults, an accept at edge N gives out_valid in the cycle after edge N+1, and the next accept is possible at edge N+3.
- An invalid operand costs one cycle: the edge still counts as a transfer and in_ready stays 1.
- in_valid is ignored while in_ready = 0; the source must hold its operand.

## Test plan

- **Reset values.** Assert rst mid-simulation with the FSM in PRE (PRE_CYC=3) → immediately out = outbar = 0x00, out_valid = 0, err = 0, in_ready = 1; no out_valid afterwards.
- **Identity lookup, defaults.** Offer in = 0x0A, inbar = 0xF5 at edge N → out_valid only in the cycle after edge N+1, with out = 0x0A, outbar = 0xF5; out = outbar = 0 in every other cycle.
- **Table write.** Write cfg_addr = 0x14, cfg_data = 0x3C, then offer in = 0x14, inbar = 0xEB → out = 0x3C, outbar = 0xC3.
- **Write collision.** Write cfg_data = 0x55 to address 0x14 on the PRE→EVAL edge of a 0x14 lookup → output 0x3C this time; 0x55 on the next lookup.
- **Rail error.** Offer in = 0x01, inbar = 0xFF →
  - err = 1, no out_valid, in_ready remains 1.
  - Then err_clr = 1 together with another invalid operand → err stays 1.
  - err_clr alone → err = 0.
- **PRE_CYC=3 back-to-back.** Hold in_valid high with operands 0x00, 0x14, 0x20 → out_valid pulses exactly 5 cycles apart with results 0x00, 0x14, 0x20 (identity table), and in_ready is low in the 4 cycles between accepts.

Source files
------------

// File: rtl/dual_rail_lut_seq.sv
// dual_rail_lut_seq
// Sequential dual-rail lookup-table engine. An operand arrives on complementary
// rails (in / inbar). Its rails are checked, the block precharges for PRE_CYC
// cycles, and then it drives the table entry on complementary output rails for
// exactly one evaluate cycle. The table can be written at run time.
//
// Parameters:
//   IN_W     operand width; the table depth is 2**IN_W
//   OUT_W    result width
//   PRE_CYC  precharge cycles per transaction (1..15)
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready is high only when idle
//   in, inbar         true and complement rails of the operand
//   cfg_we/addr/data  table write port, usable in every state
//   out, outbar       true and complement rails of the result (0/0 = precharged)
//   out_valid         high for the single evaluate cycle
//   err, err_clr      sticky rail-violation flag and its clear

module dual_rail_lut_seq #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8,
    parameter int PRE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic [IN_W-1:0]  inbar,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] outbar,
    output logic             out_valid,
    output logic             err,
    input  logic             err_clr
);

    localparam int DEPTH = 2 ** IN_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;

    // Counter load value: the counter reaches zero in the last precharge cycle.
    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);

    // A dual-rail operand is well formed only when every bit pair is complementary.
    function automatic logic rails_ok(input logic [IN_W-1:0] t, input logic [IN_W-1:0] c);
        return &(t ^ c);
    endfunction

    // Reset contents of an entry: its own index, truncated or zero-extended.
    function automatic logic [OUT_W-1:0] identity(input int idx);
        return OUT_W'(idx);
    endfunction

    logic [1:0]       state_r;
    logic [3:0]       cnt_r;
    logic [IN_W-1:0]  addr_r;
    logic [OUT_W-1:0] out_r;
    logic [OUT_W-1:0] outbar_r;
    logic             out_valid_r;
    logic             ready_r;
    logic             err_r;
    logic [OUT_W-1:0] table_r [DEPTH];

    logic [1:0]       state_s;
    logic [3:0]       cnt_s;
    logic [IN_W-1:0]  addr_s;
    logic [OUT_W-1:0] out_s;
    logic [OUT_W-1:0] outbar_s;
    logic             out_valid_s;
    logic             ready_s;
    logic             err_s;
    logic             ok_s;
    logic             bad_s;
    logic [OUT_W-1:0] rd_s;

    assign ok_s  = rails_ok(in, inbar);
    assign bad_s = (state_r == ST_IDLE) && in_valid && !ok_s;
    // Read of the current table contents; sampled into out_r on the PRE->EVAL
    // edge, so a write on that same edge is not seen until the next lookup.
    assign rd_s  = table_r[addr_r];

    // Next-state, counter and output-rail computation for the sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        addr_s      = addr_r;
        out_s       = {OUT_W{1'b0}};
        outbar_s    = {OUT_W{1'b0}};
        out_valid_s = 1'b0;
        ready_s     = ready_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && ok_s) begin
                    state_s = ST_PRE;
                    cnt_s   = PRE_LOAD;
                    addr_s  = in;
                    ready_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt_r == 4'd0) begin
                    state_s     = ST_EVAL;
                    out_s       = rd_s;
                    outbar_s    = ~rd_s;
                    out_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_EVAL: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // Sticky error: a bad operand sets it and wins over a simultaneous clear.
    always_comb begin
        err_s = err_r;
        if (bad_s) begin
            err_s = 1'b1;
        end else if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // Sequencer state, operand address and registered output rails.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= {IN_W{1'b0}};
            out_r       <= {OUT_W{1'b0}};
            outbar_r    <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            ready_r     <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            addr_r      <= addr_s;
            out_r       <= out_s;
            outbar_r    <= outbar_s;
            out_valid_r <= out_valid_s;
            ready_r     <= ready_s;
            err_r       <= err_s;
        end
    end

    // Lookup table storage: identity on reset, written from the cfg port otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[IN_W'(i)] <= identity(i);
            end
        end else if (cfg_we) begin
            table_r[cfg_addr] <= cfg_data;
        end
    end

    assign in_ready  = ready_r;
    assign out       = out_r;
    assign outbar    = outbar_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule

// File: tb/tb_dual_rail_lut_seq.sv
// Bench for dual_rail_lut_seq. Two instances (PRE_CYC=1 and PRE_CYC=3) share
// the same stimulus. A reference model tracks, per instance, the table contents,
// how many cycles remain until the block is ready again, and the sticky error;
// it pushes the expected result and the cycle in which it must appear into a
// queue. A monitor on the falling edge pops and compares.

module tb_dual_rail_lut_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, cfg_we, err_clr;
    logic [7:0] in_d, inbar_d, cfg_addr, cfg_data;

    logic [7:0] out_v [2];
    logic [7:0] outbar_v [2];
    logic       rdy_v [2];
    logic       ov_v [2];
    logic       err_v [2];

    dual_rail_lut_seq #(.IN_W(8), .OUT_W(8), .PRE_CYC(1)) dut_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .in(in_d), .inbar(inbar_d), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .out(out_v[0]), .outbar(outbar_v[0]),
        .out_valid(ov_v[0]), .err(err_v[0]), .err_clr(err_clr)
    );

    dual_rail_lut_seq #(.IN_W(8), .OUT_W(8), .PRE_CYC(3)) dut_p3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .in(in_d), .inbar(inbar_d), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .out(out_v[1]), .outbar(outbar_v[1]),
        .out_valid(ov_v[1]), .err(err_v[1]), .err_clr(err_clr)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       q [2][$];
    logic [7:0] tbl_m [2][256];
    logic [7:0] addr_m [2];
    int         rem_m [2];
    logic       err_m [2];
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    function automatic int pc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (PRE_CYC=%0d) cycle %0d: got %0h expected %0h", name, pc(inst), cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 256; a++) tbl_m[i][a] = 8'(a);
            rem_m[i] = 0;
            err_m[i] = 1'b0;
            addr_m[i] = 8'h00;
            q[i].delete();
        end
    endtask

    // Reference model: one step per rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rem_m[i] == 0) begin
                    if (in_valid && ((in_d ^ inbar_d) == 8'hFF)) begin
                        addr_m[i] = in_d;
                        rem_m[i]  = pc(i) + 1;
                    end
                    if (in_valid && ((in_d ^ inbar_d) != 8'hFF)) err_m[i] = 1'b1;
                    else if (err_clr) err_m[i] = 1'b0;
                end else begin
                    if (err_clr) err_m[i] = 1'b0;
                    rem_m[i]--;
                    // Last precharge edge: old table contents are looked up.
                    if (rem_m[i] == 1) q[i].push_back('{tbl_m[i][addr_m[i]], cyc});
                end
                if (cfg_we) tbl_m[i][cfg_addr] = cfg_data;
            end
        end
    end

    // Monitor: compares outputs each falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (q[i].size() != 0 && q[i][0].c <= cyc) begin
                    exp_t e;
                    logic [7:0] nb;
                    e  = q[i].pop_front();
                    nb = ~e.d;
                    check("out_valid", i, ov_v[i], 1'b1);
                    if (ov_v[i]) begin
                        check("out", i, out_v[i], e.d);
                        check("outbar", i, outbar_v[i], nb);
                    end
                end else begin
                    check("out_valid", i, ov_v[i], 1'b0);
                    check("precharge", i, {out_v[i], outbar_v[i]}, 16'h0000);
                end
                check("in_ready", i, rdy_v[i], rem_m[i] == 0);
                check("err", i, err_v[i], err_m[i]);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] ab,
                         input logic we, input logic [7:0] ca, input logic [7:0] cd,
                         input logic clr);
        @(negedge clk);
        in_valid = v; in_d = a; inbar_d = ab;
        cfg_we = we; cfg_addr = ca; cfg_data = cd; err_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic lookup(input logic [7:0] a);
        drive(1'b1, a, ~a, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] ops [3];
        cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_d = 8'h00; inbar_d = 8'h00;
        cfg_we = 1'b0; cfg_addr = 8'h00; cfg_data = 8'h00; err_clr = 1'b0;
        reset_model();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out", i, {out_v[i], outbar_v[i]}, 16'h0000);
            check("rst_valid", i, ov_v[i], 1'b0);
            check("rst_err", i, err_v[i], 1'b0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Identity lookup.
        lookup(8'h0A);
        idle(6);

        // Table write then lookup.
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h14, 8'h3C, 1'b0);
        lookup(8'h14);
        idle(6);

        // Write on the PRE->EVAL edge of the PRE_CYC=1 lookup.
        lookup(8'h14);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h14, 8'h55, 1'b0);
        idle(6);
        lookup(8'h14);
        idle(6);

        // Rail errors and clear priority.
        drive(1'b1, 8'h01, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 8'h02, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(2);

        // Randomised traffic over a small address window to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] a, ab;
            a  = 8'($urandom_range(0, 15));
            ab = ~a;
            if ($urandom_range(0, 9) == 0) ab = ab ^ (8'h01 << $urandom_range(0, 7));
            drive($urandom_range(0, 99) < 40, a, ab,
                  $urandom_range(0, 4) == 0, 8'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 9) == 0);
        end
        idle(6);

        // Reset while both instances are precharging, with err already set.
        drive(1'b1, 8'h01, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        lookup(8'h33);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_pre_out", i, {out_v[i], outbar_v[i]}, 16'h0000);
            check("rst_pre_valid", i, ov_v[i], 1'b0);
            check("rst_pre_err", i, err_v[i], 1'b0);
        end
        in_valid = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check("rst_pre_ready", i, rdy_v[i], 1'b1);
        idle(8);

        // Back-to-back with in_valid held; PRE_CYC=3 accepts every 5 cycles.
        ops[0] = 8'h00; ops[1] = 8'h14; ops[2] = 8'h20;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 5; j++) lookup(ops[k]);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
